// File: rtl/lsb_stego_extractor.sv
// Receive side of the encrypted LSB steganography path: recovers a length header and
// an XOR-encrypted payload from cover-pixel LSBs and streams out the plaintext bytes.
//
// state   | meaning
// IDLE    | waiting for start_i after reset
// HDR     | collecting the 8 header LSBs (payload length N)
// PAYLOAD | collecting payload bytes, decrypting, handing off over byte_o
// DONE    | all N bytes delivered (or N=0); waiting for the next start_i
module lsb_stego_extractor #(
  parameter logic [7:0] LFSR_TAPS = 8'hB8,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       wb_rst_n,
  input  logic       start_i,
  input  logic [7:0] key_i,
  input  logic [7:0] pix_i,
  input  logic       pix_valid_i,
  output logic       pix_ready_o,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  input  logic       byte_ready_i,
  output logic [7:0] len_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic [7:0] lfsr;
  logic [7:0] byte_cnt;
  logic [7:0] shift_nxt;
  logic [7:0] lfsr_nxt;
  logic       pix_acc;
  logic       byte_hs;
  logic       unused_pix;

  assign pix_acc    = pix_valid_i & pix_ready_o;
  assign byte_hs    = byte_valid_o & byte_ready_i;
  assign shift_nxt  = MSB_FIRST ? {shift_q[6:0], pix_i[0]} : {pix_i[0], shift_q[7:1]};
  assign lfsr_nxt   = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 8'h00);
  assign unused_pix = ^pix_i[7:1];

  always_ff @(posedge clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift_q      <= 8'h00;
      lfsr         <= 8'h00;
      byte_cnt     <= 8'h00;
      byte_o       <= 8'h00;
      byte_valid_o <= 1'b0;
      len_o        <= 8'h00;
      pix_ready_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            state       <= HDR;
            // an all-zero seed would lock the LFSR at zero
            lfsr        <= (key_i == 8'h00) ? 8'h01 : key_i;
            bit_cnt     <= 3'd0;
            shift_q     <= 8'h00;
            byte_cnt    <= 8'h00;
            pix_ready_o <= 1'b1;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
          end
        end
        HDR: begin
          if (pix_acc) begin
            shift_q <= shift_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              len_o <= shift_nxt;
              if (shift_nxt == 8'h00) begin
                state       <= DONE;
                pix_ready_o <= 1'b0;
                busy_o      <= 1'b0;
                done_o      <= 1'b1;
              end else begin
                state    <= PAYLOAD;
                byte_cnt <= 8'h00;
              end
            end
          end
        end
        PAYLOAD: begin
          // pix_ready_o is low while a byte is pending, so accept and handshake never coincide
          if (pix_acc) begin
            shift_q <= shift_nxt;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              byte_o       <= shift_nxt ^ lfsr;
              byte_valid_o <= 1'b1;
              pix_ready_o  <= 1'b0;
              lfsr         <= lfsr_nxt;
              byte_cnt     <= byte_cnt + 8'd1;
            end
          end
          if (byte_hs) begin
            byte_valid_o <= 1'b0;
            byte_o       <= 8'h00;
            if (byte_cnt == len_o) begin
              state  <= DONE;
              busy_o <= 1'b0;
              done_o <= 1'b1;
            end else begin
              pix_ready_o <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsb_stego_extractor.sv
// Self-checking bench for lsb_stego_extractor: vector table of key/length/cipher records,
// expected plaintext queued at stimulus time and popped on each byte handshake.
module tb_lsb_stego_extractor;

  logic       clk = 1'b0;
  logic       wb_rst_n;
  logic       start_i;
  logic [7:0] key_i;
  logic [7:0] pix_i;
  logic       pix_valid_i;
  logic       pix_ready_o;
  logic [7:0] byte_o;
  logic       byte_valid_o;
  logic       byte_ready_i;
  logic [7:0] len_o;
  logic       busy_o;
  logic       done_o;

  lsb_stego_extractor dut (
    .clk(clk), .wb_rst_n(wb_rst_n), .start_i(start_i), .key_i(key_i),
    .pix_i(pix_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
    .len_o(len_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    logic [7:0] len;
    logic [7:0] c [3];
    logic [7:0] p [3];
    bit         start_mid;
    bit         bp;
  } vec_t;

  int         checks = 0;
  int         failures = 0;
  int         valid_pulses = 0;
  logic       prev_valid = 1'b0;
  bit         bp_en = 1'b0;
  int         hold = 0;
  logic [7:0] exp_q [$];
  vec_t       vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] key, input logic [7:0] len,
                              input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                              input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                              input bit start_mid, input bit bp);
    vec_t v;
    v.key = key; v.len = len;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2;
    v.start_mid = start_mid; v.bp = bp;
    return v;
  endfunction

  // downstream sink: optional 5-cycle stall on every byte
  always @(posedge clk) begin
    #1;
    if (!byte_valid_o) begin
      hold = 0;
      byte_ready_i = 1'b1;
    end else if (bp_en && hold < 5) begin
      byte_ready_i = 1'b0;
      hold++;
    end else begin
      byte_ready_i = 1'b1;
    end
  end

  // output monitor / scoreboard
  always @(negedge clk) begin
    if (byte_valid_o && !prev_valid) valid_pulses++;
    prev_valid = byte_valid_o;
    if (byte_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL byte_unexpected actual=%0h required=none", byte_o);
      end else if (byte_ready_i) begin
        check("byte_data", {24'h0, byte_o}, {24'h0, exp_q.pop_front()});
      end else begin
        check("bp_hold_data", {24'h0, byte_o}, {24'h0, exp_q[0]});
        check("bp_pix_ready", {31'h0, pix_ready_o}, 32'h0);
      end
    end
  end

  task automatic send_bit(input logic b);
    bit acc = 1'b0;
    int guard = 0;
    while (!acc) begin
      if ($urandom_range(0, 4) == 0) begin
        pix_valid_i = 1'b0;
        pix_i = 8'($urandom);
        @(posedge clk); #1;
      end
      pix_valid_i = 1'b1;
      pix_i = {7'($urandom), b};
      @(negedge clk);
      acc = pix_ready_o;
      @(posedge clk); #1;
      guard++;
      if (!acc && guard > 50) begin
        checks++;
        failures++;
        $display("FAIL pix_accept_timeout actual=not_ready required=ready");
        acc = 1'b1;
      end
    end
    pix_valid_i = 1'b0;
  endtask

  task automatic pulse_start(input logic [7:0] key);
    start_i = 1'b1;
    key_i = key;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    logic [7:0] hdr;
    logic [7:0] cb;
    int p0;
    int g;
    bp_en = v.bp;
    pulse_start(v.key);
    check("start_busy", {31'h0, busy_o}, 32'h1);
    check("start_done_low", {31'h0, done_o}, 32'h0);
    hdr = v.len;
    for (int i = 7; i >= 0; i--) send_bit(hdr[i]);
    check("len_o", {24'h0, len_o}, {24'h0, v.len});
    p0 = valid_pulses;
    if (v.len == 8'h00) begin
      check("zero_len_done", {30'h0, done_o, busy_o}, 32'h2);
      repeat (4) @(posedge clk);
      #1;
      check("zero_len_no_valid", 32'(valid_pulses - p0), 32'h0);
      check("zero_len_pix_ready", {31'h0, pix_ready_o}, 32'h0);
    end else begin
      if (v.start_mid) begin
        pulse_start(8'hFF);
        check("mid_start_ignored", {30'h0, busy_o, done_o}, 32'h2);
      end
      for (int k = 0; k < int'(v.len); k++) begin
        exp_q.push_back(v.p[k]);
        cb = v.c[k];
        for (int i = 7; i >= 0; i--) send_bit(cb[i]);
        check("valid_latency", {31'h0, byte_valid_o}, 32'h1);
      end
      g = 0;
      while (!done_o && g < 200) begin
        @(posedge clk); #1;
        g++;
      end
      check("end_done", {30'h0, done_o, busy_o}, 32'h2);
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      check("valid_pulse_count", 32'(valid_pulses - p0), {24'h0, v.len});
    end
    bp_en = 1'b0;
  endtask

  initial begin
    vecs[0] = mk(8'h5A, 8'd1, 8'h1B, 8'h00, 8'h00, 8'h41, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[1] = mk(8'h5A, 8'd2, 8'h1B, 8'h6C, 8'h00, 8'h41, 8'h41, 8'h00, 1'b1, 1'b0);
    vecs[2] = mk(8'h00, 8'd1, 8'h40, 8'h00, 8'h00, 8'h41, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[3] = mk(8'h5A, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    vecs[4] = mk(8'h5A, 8'd3, 8'h1B, 8'h6C, 8'hED, 8'h41, 8'h41, 8'h43, 1'b0, 1'b1);
    vecs[5] = mk(8'h01, 8'd2, 8'h40, 8'hFA, 8'h00, 8'h41, 8'h42, 8'h00, 1'b0, 1'b1);

    wb_rst_n = 1'b0;
    start_i = 1'b0;
    key_i = 8'h00;
    pix_i = 8'h00;
    pix_valid_i = 1'b0;
    byte_ready_i = 1'b1;
    #22 wb_rst_n = 1'b1;

    pix_valid_i = 1'b1;
    pix_i = 8'hFF;
    repeat (10) begin
      @(negedge clk);
      check("idle_outputs", {5'h0, byte_o, byte_valid_o, len_o, pix_ready_o, busy_o, done_o}, 32'h0);
    end
    pix_valid_i = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 6; n++) run_vector(vecs[n]);

    pulse_start(8'h5A);
    for (int i = 7; i >= 0; i--) send_bit(i == 0);
    exp_q.push_back(8'h41);
    for (int i = 7; i >= 4; i--) send_bit(1'b1);
    wb_rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {5'h0, byte_o, byte_valid_o, len_o, pix_ready_o, busy_o, done_o}, 32'h0);
    exp_q.delete();
    #2 wb_rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", {29'h0, pix_ready_o, busy_o, done_o}, 32'h0);
    run_vector(vecs[0]);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsb_stego_extractor.md
Name: lsb_stego_extractor

Overview:
Receive end of the encrypted LSB steganography path. The block takes a stream of cover pixels and collects the LSB of each one. The first 8 LSBs form a plaintext length header N. The next 8·N LSBs are assembled into bytes, XOR-decrypted with an 8-bit LFSR keystream seeded from a key, and delivered over a valid/ready byte port. It sits in the user project area beside the embedder, fed from io pins or LA.

Parameters:
LFSR_TAPS, 8'hB8, Galois feedback mask; the LFSR shifts right.
MSB_FIRST, 1, 1: the first extracted bit of each byte is bit 7; 0: it is bit 0.

Ports:
clk  input  1  single block clock.
wb_rst_n  input  1  asynchronous active-low reset.
start_i  input  1  one-cycle pulse that begins an extraction; sampled only in IDLE or DONE.
key_i  input  8  LFSR seed, captured on an accepted start.
pix_i  input  8  cover pixel; only bit 0 is used.
pix_valid_i  input  1  pixel valid.
pix_ready_o  output  1  pixel accepted when valid and ready are both high.
byte_o  output  8  decrypted payload byte.
byte_valid_o  output  1  byte_o is valid.
byte_ready_i  input  1  downstream accepts the byte.
len_o  output  8  captured header length N.
busy_o  output  1  high in the HDR and PAYLOAD states.
done_o  output  1  high in the DONE state.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (wb_rst_n).
- Reset values:
  - state = IDLE.
  - All outputs are 0: byte_o, byte_valid_o, len_o, pix_ready_o, busy_o, done_o.
  - Bit counter = 0, shift register = 0, LFSR = 0.
- Reset mid-operation aborts immediately. Any pending byte_valid_o is dropped.
- FSM states: IDLE, HDR, PAYLOAD, DONE.
  - IDLE or DONE, start_i=1: load the LFSR with key_i (a zero key is replaced by 8'h01), clear the bit counter, go to HDR. done_o falls the next cycle.
  - HDR: pix_ready_o=1. Each accepted pixel shifts in pix_i[0] and increments the bit counter.
  - HDR, 8th accepted bit: len_o <= the assembled value. If the value is 0, go to DONE; otherwise go to PAYLOAD with the byte counter = 0.
  - PAYLOAD: pix_ready_o = !byte_valid_o. On the 8th accepted bit of a byte:
    - byte_o <= assembled ^ lfsr
    - byte_valid_o <= 1 on the next edge (1-cycle latency from the last accepted pixel)
    - LFSR advances: lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0)
    - byte counter increments
  - byte_valid_o and byte_o are held stable until byte_ready_i=1. They clear on the handshake edge.
  - The handshake of byte N moves the FSM to DONE.
  - DONE: done_o=1 and pix_ready_o=0. Remains here until start_i.
- Keystream: byte k is XORed with the LFSR state after k advances; byte 0 uses the seed.
- Bit assembly:
  - MSB_FIRST=1: shift <= {shift[6:0], bit}.
  - MSB_FIRST=0: shift <= {bit, shift[7:1]}.
  - The header uses the same order.
- Pixels are ignored (not accepted) in IDLE and DONE, and whenever pix_ready_o=0.
- start_i is ignored in HDR and PAYLOAD.
- Counter and length rules:
  - The bit counter is 3 bits and wraps 7→0 at each byte boundary.
  - The byte counter is 8 bits; N ranges 1..255 and there is no overflow.
- pix_ready_o is registered/state-derived only. It has no combinational path from byte_ready_i. Throughput is 8 pixels plus at least 1 cycle per byte.
- busy_o and done_o are never high at the same time.

Test Plan:
- Reset, then no start, with pix_valid_i held high: every output stays 0 and no pixel is accepted.
- Single-byte decrypt:
  - Stimulus: key_i=8'h5A, start; header LSBs 0,0,0,0,0,0,0,1; payload LSBs 0,0,0,1,1,0,1,1 (cipher 8'h1B); byte_ready_i=1.
  - Required: len_o=1, byte_o=8'h41 with one valid pulse one cycle after the 8th payload pixel, then done_o=1.
- Keystream advance:
  - Stimulus: key 8'h5A, N=2, cipher bytes 8'h1B and 8'h6C.
  - Required: bytes 8'h41 then 8'h41 (second keystream byte 8'h2D).
  - Also drive start_i during PAYLOAD: it must be ignored.
- Backpressure: byte_ready_i=0 for 5 cycles after byte_valid_o rises. byte_o must stay stable, pix_ready_o must stay 0, and no pixels may be lost. After ready rises, extraction resumes.
- Boundary cases:
  - Header 8'h00: DONE directly after 8 pixels, with no byte_valid_o.
  - key_i=0: the seed behaves as 8'h01 (cipher 8'h40 decrypts to 8'h41).
- Reset mid-payload: assert wb_rst_n=0 after 4 payload bits. All outputs clear immediately (asynchronously). A new start then decodes correctly from scratch.
